// File: rtl/mc_rd_stream.sv
// mc_rd_stream: sequential 8-byte read engine for one memory-controller port.
// Reads are tagged with a rolling slot index, responses land in a tag-indexed
// reorder buffer, and data leaves on a valid/ready stream in address order.
module mc_rd_stream #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int NUM_TAGS     = 16
) (
    input  logic                    clk,
    input  logic                    i_reset_n,
    input  logic                    start,
    input  logic [47:0]             base_addr,
    input  logic [31:0]             num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mc_rq_vld,
    output logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic [63:0]             mc_rq_data,
    output logic [47:0]             mc_rq_vadr,
    output logic [1:0]              mc_rq_size,
    output logic [2:0]              mc_rq_cmd,
    output logic [3:0]              mc_rq_scmd,
    input  logic                    mc_rq_stall,
    input  logic                    mc_rs_vld,
    input  logic [2:0]              mc_rs_cmd,
    input  logic [3:0]              mc_rs_scmd,
    input  logic [63:0]             mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic                    mc_rs_stall,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NUM_TAGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                busy_r, done_r, busy_nxt_s, done_nxt_s;
    logic [47:0]         addr_r;
    logic [31:0]         remaining_r;
    logic [TAG_W:0]      outstanding_r;
    logic [TAG_W-1:0]    issue_ptr_r, rd_ptr_r;
    logic                rq_vld_r;
    logic [47:0]         rq_vadr_r;
    logic [TAG_W-1:0]    rq_tag_r;
    logic [NUM_TAGS-1:0] valid_r, valid_nxt_s;
    logic [63:0]         slot_r [NUM_TAGS];
    logic                err_r, err_nxt_s;

    logic                start_idle_s, start_bad_s, start_ok_s, start_run_s;
    logic                accept_s, pop_s, load_s;
    logic [TAG_W:0]      issued_cnt_s;
    logic [TAG_W-1:0]    rs_tag_s, rs_offset_s;
    logic                rs_tag_ok_s, rs_in_window_s, rs_write_s, rs_bad_s;
    logic                unused_scmd_s;

    assign unused_scmd_s = ^mc_rs_scmd;

    assign start_idle_s = start && (state_r == ST_IDLE);
    assign start_bad_s  = start_idle_s && (base_addr[2:0] != 3'd0);
    assign start_ok_s   = start_idle_s && (base_addr[2:0] == 3'd0);
    assign start_run_s  = start_ok_s && (num_words != 32'd0);

    // A held request leaves when the controller stops stalling; the next one
    // may be loaded in the same cycle so back-to-back issue is sustained.
    assign accept_s = rq_vld_r && !mc_rq_stall;
    assign pop_s    = out_valid && out_ready;
    assign load_s   = (state_r == ST_RUN) && (remaining_r != 32'd0) &&
                      (!rq_vld_r || !mc_rq_stall) &&
                      ((outstanding_r < FULL_CNT) || pop_s);

    // outstanding_r also counts a request still sitting in the issue register;
    // that one has not reached the controller, so it cannot legally return yet.
    assign issued_cnt_s   = outstanding_r - {{TAG_W{1'b0}}, rq_vld_r};
    assign rs_tag_s       = mc_rs_rtnctl[TAG_W-1:0];
    assign rs_tag_ok_s    = ((mc_rs_rtnctl >> TAG_W) == {RTNCTL_WIDTH{1'b0}});
    assign rs_offset_s    = rs_tag_s - rd_ptr_r;
    assign rs_in_window_s = ({1'b0, rs_offset_s} < issued_cnt_s);
    // A write to an occupied slot (including the one being popped) is dropped.
    assign rs_write_s     = mc_rs_vld && (mc_rs_cmd == 3'd2) && rs_tag_ok_s &&
                            rs_in_window_s && !valid_r[rs_tag_s];
    assign rs_bad_s       = mc_rs_vld && !rs_write_s;

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign mc_rq_vld    = rq_vld_r;
    assign mc_rq_vadr   = rq_vadr_r;
    assign mc_rq_rtnctl = {{(RTNCTL_WIDTH-TAG_W){1'b0}}, rq_tag_r};
    assign mc_rq_data   = 64'd0;
    assign mc_rq_size   = 2'd3;
    assign mc_rq_cmd    = 3'd1;
    assign mc_rq_scmd   = 4'd0;
    assign mc_rs_stall  = 1'b0;
    assign out_valid    = valid_r[rd_ptr_r];
    assign out_data     = slot_r[rd_ptr_r];

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic for the stream sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_bad_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (start_run_s) begin
                    state_nxt_s = ST_RUN;
                end else if (start_ok_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (remaining_r == 32'd0) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_r == {(TAG_W+1){1'b0}}) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: busy while streaming, done for the single FIN cycle.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN, ST_DRAIN: busy_nxt_s = 1'b1;
            ST_FIN:           done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Request issue register: address walk, tag assignment and stall hold.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_r      <= 48'd0;
            remaining_r <= 32'd0;
            issue_ptr_r <= {TAG_W{1'b0}};
            rq_vld_r    <= 1'b0;
            rq_vadr_r   <= 48'd0;
            rq_tag_r    <= {TAG_W{1'b0}};
        end else if (start_run_s) begin
            addr_r      <= base_addr;
            remaining_r <= num_words;
        end else if (load_s) begin
            rq_vld_r    <= 1'b1;
            rq_vadr_r   <= addr_r;
            rq_tag_r    <= issue_ptr_r;
            addr_r      <= addr_r + 48'd8;
            issue_ptr_r <= issue_ptr_r + TAG_W'(1);
            remaining_r <= remaining_r - 32'd1;
        end else if (accept_s) begin
            rq_vld_r    <= 1'b0;
        end
    end

    // Slots in flight and the in-order read pointer of the reorder buffer.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            outstanding_r <= {(TAG_W+1){1'b0}};
            rd_ptr_r      <= {TAG_W{1'b0}};
        end else begin
            case ({load_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + (TAG_W+1)'(1);
                2'b01:   outstanding_r <= outstanding_r - (TAG_W+1)'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + TAG_W'(1);
            end
        end
    end

    // Per-slot valid bits: set by an accepted response, cleared by a pop.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (rs_write_s && (rs_tag_s == TAG_W'(i))) begin
                valid_nxt_s[i] = 1'b1;
            end else if (pop_s && (rd_ptr_r == TAG_W'(i))) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
            end
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_r <= {NUM_TAGS{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Reorder-buffer data storage, written by accepted responses.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                slot_r[i] <= 64'd0;
            end
        end else if (rs_write_s) begin
            slot_r[rs_tag_s] <= mc_rs_data;
        end
    end

    // Sticky error: bad responses win over the clear from an accepted start.
    always_comb begin
        err_nxt_s = err_r;
        if (rs_bad_s) begin
            err_nxt_s = 1'b1;
        end else if (start_ok_s) begin
            err_nxt_s = 1'b0;
        end else if (start_bad_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mc_rd_stream.sv
// Directed-plus-random bench for mc_rd_stream. A memory model supplies data
// per address; accepted requests, responses and popped words are logged and
// compared against the address sequence and data implied by each start.
module tb_mc_rd_stream;
    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        start;
    logic [47:0] base_addr;
    logic [31:0] num_words;
    logic        busy, done, err;
    logic        mc_rq_vld;
    logic [31:0] mc_rq_rtnctl;
    logic [63:0] mc_rq_data;
    logic [47:0] mc_rq_vadr;
    logic [1:0]  mc_rq_size;
    logic [2:0]  mc_rq_cmd;
    logic [3:0]  mc_rq_scmd;
    logic        mc_rq_stall;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [3:0]  mc_rs_scmd;
    logic [63:0] mc_rs_data;
    logic [31:0] mc_rs_rtnctl;
    logic        mc_rs_stall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    always #5 clk = ~clk;

    mc_rd_stream #(.RTNCTL_WIDTH(32), .NUM_TAGS(NT)) dut (
        .clk(clk), .i_reset_n(i_reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .err(err),
        .mc_rq_vld(mc_rq_vld), .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_cmd(mc_rq_cmd),
        .mc_rq_scmd(mc_rq_scmd), .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld),
        .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data),
        .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [47:0] acc_addr[$];
    logic [31:0] acc_tag[$];
    int          pend[$];
    logic [63:0] out_log[$];
    int          done_cnt = 0;
    int          tag_base = 0;
    logic [31:0] salt = 32'h1234_5678;
    bit          hold_rq = 1'b0;
    logic [47:0] hold_vadr;
    logic [31:0] hold_tag;
    bit          hold_out = 1'b0;
    logic [63:0] hold_data;

    function automatic logic [63:0] mem_of(input logic [47:0] a);
        return {a[47:16] ^ salt, a[31:0] ^ 32'h5A5A_0F0F};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observe at the falling edge what the next rising edge will commit, then advance.
    task automatic tick();
        @(negedge clk);
        if (hold_rq) begin
            chk("stall_hold_vld", 64'(mc_rq_vld), 64'd1);
            chk("stall_hold_vadr", 64'(mc_rq_vadr), 64'(hold_vadr));
            chk("stall_hold_tag", 64'(mc_rq_rtnctl), 64'(hold_tag));
        end
        if (hold_out) begin
            chk("out_hold_valid", 64'(out_valid), 64'd1);
            chk("out_hold_data", out_data, hold_data);
        end
        hold_rq   = mc_rq_vld && mc_rq_stall;
        hold_vadr = mc_rq_vadr;
        hold_tag  = mc_rq_rtnctl;
        hold_out  = out_valid && !out_ready;
        hold_data = out_data;
        if (mc_rq_vld && !mc_rq_stall) begin
            acc_addr.push_back(mc_rq_vadr);
            acc_tag.push_back(mc_rq_rtnctl);
            pend.push_back(acc_addr.size() - 1);
        end
        if (out_valid && out_ready) out_log.push_back(out_data);
        if (done) begin
            done_cnt++;
            chk("busy_at_done", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [47:0] b, input int n);
        acc_addr.delete(); acc_tag.delete(); pend.delete(); out_log.delete();
        done_cnt = 0;
        salt = $urandom;
        base_addr = b; num_words = 32'(n); start = 1'b1; mc_rs_vld = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic step(input int stall_pct, input int ready_pct, input int resp_pct, input bit inorder);
        int k, idx;
        mc_rq_stall = ($urandom_range(99) < stall_pct);
        out_ready   = ($urandom_range(99) < ready_pct);
        if (pend.size() != 0 && $urandom_range(99) < resp_pct) begin
            k = inorder ? 0 : int'($urandom_range(pend.size() - 1));
            idx = pend[k];
            pend.delete(k);
            mc_rs_vld = 1'b1; mc_rs_cmd = 3'd2;
            mc_rs_rtnctl = acc_tag[idx]; mc_rs_data = mem_of(acc_addr[idx]);
        end else begin
            mc_rs_vld = 1'b0;
        end
        tick();
        mc_rs_vld = 1'b0;
    endtask

    task automatic respond(input int idx, input logic [2:0] cmd, input logic [63:0] data, input bit consume);
        mc_rs_vld = 1'b1; mc_rs_cmd = cmd; mc_rs_rtnctl = acc_tag[idx]; mc_rs_data = data;
        tick();
        mc_rs_vld = 1'b0; mc_rs_cmd = 3'd2;
        if (consume) begin
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k] == idx) begin
                    pend.delete(k);
                    break;
                end
            end
        end
    endtask

    task automatic wait_acc(input int k);
        for (int c = 0; c < 100 && acc_addr.size() < k; c++) step(0, 0, 0, 1'b1);
        chk("issued_before_hold", 64'(acc_addr.size()), 64'(k));
    endtask

    task automatic run_until_done(input int budget, input int stall_pct, input int ready_pct,
                                  input int resp_pct, input bit inorder);
        for (int c = 0; c < budget && done_cnt == 0; c++) step(stall_pct, ready_pct, resp_pct, inorder);
        mc_rq_stall = 1'b0;
    endtask

    task automatic verify(input logic [47:0] b, input int n, input logic exp_err);
        logic [47:0] ea;
        out_ready = 1'b0;
        tick();
        tick();
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("req_count", 64'(acc_addr.size()), 64'(n));
        for (int i = 0; i < n && i < acc_addr.size(); i++) begin
            ea = b + 48'(8 * i);
            chk("req_vadr", 64'(acc_addr[i]), 64'(ea));
            chk("req_tag", 64'(acc_tag[i]), 64'((tag_base + i) % NT));
        end
        chk("out_count", 64'(out_log.size()), 64'(n));
        for (int i = 0; i < n && i < out_log.size(); i++) begin
            ea = b + 48'(8 * i);
            chk("out_data", out_log[i], mem_of(ea));
        end
        chk("err_end", 64'(err), 64'(exp_err));
        chk("busy_end", 64'(busy), 64'd0);
        chk("rq_vld_end", 64'(mc_rq_vld), 64'd0);
        tag_base = (tag_base + n) % NT;
    endtask

    task automatic run_random(input logic [47:0] b, input int n, input int stall_pct,
                              input int ready_pct, input int resp_pct, input bit inorder);
        start_stream(b, n);
        chk("busy_after_start", 64'(busy), 64'd1);
        run_until_done(4000, stall_pct, ready_pct, resp_pct, inorder);
        verify(b, n, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rq_vld"}, 64'(mc_rq_vld), 64'd0);
        chk({tag, "_rq_vadr"}, 64'(mc_rq_vadr), 64'd0);
        chk({tag, "_rq_rtnctl"}, 64'(mc_rq_rtnctl), 64'd0);
        chk({tag, "_rq_data"}, mc_rq_data, 64'd0);
        chk({tag, "_rq_size"}, 64'(mc_rq_size), 64'd3);
        chk({tag, "_rq_cmd"}, 64'(mc_rq_cmd), 64'd1);
        chk({tag, "_rq_scmd"}, 64'(mc_rq_scmd), 64'd0);
        chk({tag, "_rs_stall"}, 64'(mc_rs_stall), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] rb;
        int          rn;
        i_reset_n = 1'b0; start = 1'b0; base_addr = 48'd0; num_words = 32'd0;
        mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_cmd = 3'd2; mc_rs_scmd = 4'd0;
        mc_rs_data = 64'd0; mc_rs_rtnctl = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        i_reset_n = 1'b1;
        tick();

        // Basic in-order stream from 0x1000.
        run_random(48'h0000_0000_1000, 4, 0, 100, 100, 1'b1);

        // Reorder: responses 3,1,0,2; nothing may leave until word 0 arrives.
        rb = 48'h0000_00AB_0000;
        start_stream(rb, 4);
        wait_acc(4);
        respond(3, 3'd2, mem_of(acc_addr[3]), 1'b1);
        respond(1, 3'd2, mem_of(acc_addr[1]), 1'b1);
        tick();
        chk("reorder_wait_valid", 64'(out_valid), 64'd0);
        respond(0, 3'd2, mem_of(acc_addr[0]), 1'b1);
        chk("reorder_head_valid", 64'(out_valid), 64'd1);
        chk("reorder_head_data", out_data, mem_of(rb));
        respond(2, 3'd2, mem_of(acc_addr[2]), 1'b1);
        run_until_done(200, 0, 100, 0, 1'b1);
        verify(rb, 4, 1'b0);

        // Backpressure: window fills at 16, one pop frees exactly one, stall holds.
        rb = 48'h0000_0001_0000;
        start_stream(rb, 40);
        repeat (60) step(0, 100, 0, 1'b1);
        chk("window_full_count", 64'(acc_addr.size()), 64'd16);
        chk("window_full_vld", 64'(mc_rq_vld), 64'd0);
        out_ready = 1'b1;
        respond(0, 3'd2, mem_of(acc_addr[0]), 1'b1);
        repeat (10) step(0, 100, 0, 1'b1);
        chk("one_freed_count", 64'(acc_addr.size()), 64'd17);
        chk("one_freed_vld", 64'(mc_rq_vld), 64'd0);
        repeat (5) step(100, 100, 100, 1'b1);
        chk("stalled_count", 64'(acc_addr.size()), 64'd17);
        chk("stalled_vld", 64'(mc_rq_vld), 64'd1);
        run_until_done(4000, 20, 70, 60, 1'b0);
        verify(rb, 40, 1'b0);

        // Zero-length stream: immediate done, no request.
        start_stream(48'h0000_0000_1000, 0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_rq_vld", 64'(mc_rq_vld), 64'd0);
        tick();
        chk("zero_done_drop", 64'(done), 64'd0);

        // Misaligned base: error, stays idle.
        start_stream(48'h0000_0000_1004, 4);
        chk("misalign_err", 64'(err), 64'd1);
        chk("misalign_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("misalign_no_req", 64'(acc_addr.size()), 64'd0);
        chk("misalign_busy_later", 64'(busy), 64'd0);

        // Bad response command: start clears err, cmd=3 sets it and is dropped.
        rb = 48'h0000_0000_2000;
        start_stream(rb, 3);
        chk("start_clears_err", 64'(err), 64'd0);
        wait_acc(3);
        respond(0, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        tick();
        chk("badcmd_err", 64'(err), 64'd1);
        chk("badcmd_dropped", 64'(out_valid), 64'd0);
        run_until_done(300, 0, 100, 100, 1'b1);
        verify(rb, 3, 1'b1);

        // Duplicate tag: second write to a full slot is dropped and flagged.
        rb = 48'h0000_0000_3000;
        start_stream(rb, 3);
        chk("start_clears_err2", 64'(err), 64'd0);
        wait_acc(3);
        respond(0, 3'd2, mem_of(acc_addr[0]), 1'b1);
        respond(0, 3'd2, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
        tick();
        chk("dup_err", 64'(err), 64'd1);
        chk("dup_data_kept", out_data, mem_of(rb));
        run_until_done(300, 0, 100, 100, 1'b1);
        verify(rb, 3, 1'b1);

        // Address wrap at the top of the 48-bit space.
        run_random(48'hFFFF_FFFF_FFF8, 2, 0, 100, 100, 1'b1);

        // Randomised streams with stalls, reordering and output backpressure.
        for (int r = 0; r < 3; r++) begin
            rb[47:32] = 16'($urandom);
            rb[31:0]  = $urandom;
            rb[2:0]   = 3'd0;
            rn = int'($urandom_range(50, 5));
            run_random(rb, rn, 20, 60, 50, 1'b0);
        end

        // Reset mid-stream after 3 of 8 requests issued.
        start_stream(48'h0000_0000_6000, 8);
        wait_acc(3);
        mc_rq_stall = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        hold_rq = 1'b0;
        hold_out = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        tag_base = 0;
        respond(1, 3'd2, mem_of(acc_addr[1]), 1'b1);
        chk("late_resp_err", 64'(err), 64'd1);
        run_random(48'h0000_0000_7000, 2, 0, 100, 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_rd_stream.md
Name: mc_rd_stream

Overview:
- Read-stream engine that feeds one memory-controller port of the personality wrapper's mc_rq_*/mc_rs_* interface.
- Issues sequential 8-byte reads from a base virtual address and tags each with a return-control ID.
- Reorders out-of-order responses in a small tag-indexed buffer and emits the data in address order on a valid/ready stream to the compute pipeline.

Parameters:
- RTNCTL_WIDTH, 32, width of the mc_rq_rtnctl/mc_rs_rtnctl fields.
- NUM_TAGS, 16, reorder-buffer depth and maximum outstanding reads; must be a power of 2, 2..64.
- TAG_W, log2(NUM_TAGS), tag width; derived, not overridable.

Ports:
- clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse
- base_addr  in  48  byte address of the first word; sampled on start
- num_words  in  32  number of 64-bit words; sampled on start
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse when the last word has left out_data
- err  out  1  sticky error flag; cleared only by reset or an accepted start
- mc_rq_vld  out  1  request valid
- mc_rq_rtnctl  out  RTNCTL_WIDTH  tag in bits [TAG_W-1:0], upper bits 0
- mc_rq_data  out  64  always 0
- mc_rq_vadr  out  48  request address
- mc_rq_size  out  2  always 3 (8 bytes)
- mc_rq_cmd  out  3  always 1 (RD)
- mc_rq_scmd  out  4  always 0
- mc_rq_stall  in  1  MC backpressure
- mc_rs_vld  in  1  response valid
- mc_rs_cmd  in  3  2 = RD_DATA
- mc_rs_scmd  in  4  ignored
- mc_rs_data  in  64  response data
- mc_rs_rtnctl  in  RTNCTL_WIDTH  returned tag
- mc_rs_stall  out  1  always 0; a buffer slot is reserved per issued read
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  64  stream data

Behaviour:
- Reset (async assert, sync deassert): all outputs 0 except the constant fields (size=3, cmd=1); FSM goes to IDLE; pointers, counters and slot-valid bits clear. A reset mid-stream abandons the stream; late responses arriving after reset set err.
- FSM states and transitions:
  - IDLE: start → if base_addr[2:0]≠0, set err and stay IDLE; if num_words=0, go to FIN; otherwise load addr, remaining, clear err, go to RUN. start is ignored in every other state.
  - RUN: issue reads; when remaining reaches 0, go to DRAIN.
  - DRAIN: when all issued words have been output, go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RUN and DRAIN.
- Request issue:
  - mc_rq_vld, vadr and rtnctl are registered.
  - A request is accepted in any cycle with mc_rq_vld=1 and mc_rq_stall=0.
  - While stalled, vld and fields hold unchanged.
  - Next-request condition: in RUN, remaining>0, and outstanding<NUM_TAGS after counting this cycle's issue and release.
  - Sustained rate is 1 request/cycle.
  - On accept: vadr+=8 (48-bit wrap), tag=issue_ptr, issue_ptr++ mod NUM_TAGS, remaining--, outstanding++.
- Response handling:
  - A response is taken when mc_rs_vld=1. If cmd≠2, or the slot is already valid, or the tag ≥ outstanding window, set err and drop it.
  - Otherwise write data to slot[tag] and set valid[tag].
  - Any order of responses is allowed.
- Output stream:
  - out_valid=valid[rd_ptr]; out_data=slot[rd_ptr] (registered read is allowed, but 1 word/cycle throughput is required).
  - On out_valid&&out_ready: clear valid[rd_ptr], rd_ptr++, outstanding--.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - An issue, a response write and an output pop in the same cycle must all take effect.
  - A response to slot X and a pop of slot X in the same cycle is impossible by construction; if it occurs, flag err.
- Latency: start to first mc_rq_vld is 2 cycles; a response written in cycle N is visible on out_valid by cycle N+2.

Test Plan:
- Basic stream: base=0x1000, num_words=4, no stall, in-order responses → vadr 0x1000, 0x1008, 0x1010, 0x1018 with tags 0..3; out_data in order; one done pulse; busy falls with done.
- Reorder: num_words=4, responses returned with tags 3,1,0,2 carrying data D3,D1,D0,D2 → out_data emitted D0,D1,D2,D3; err=0.
- Backpressure:
  - num_words=40, responses withheld → exactly 16 requests issued, then mc_rq_vld=0.
  - Returning 1 response and popping it → exactly 1 more request.
  - mc_rq_stall held for 5 cycles → vadr/rtnctl unchanged, no request lost or duplicated.
  - out_ready=0 → out_data stable.
- Boundaries:
  - num_words=0 → no request, done 1 cycle after start.
  - base=0x1004 → err=1, stays IDLE.
  - base=0xFFFF_FFFF_FFF8, num_words=2 → second vadr=0x0.
- Errors: response with cmd=3, or a duplicate tag 0 → err=1 and data dropped; a subsequent valid start clears err.
- Reset mid-stream: assert i_reset_n=0 after 3 of 8 requests are issued → all outputs 0 immediately; after release, a new start of 2 words runs cleanly.
